updown_seq_ctrl: RTL

Sequencer that drives an N-bit up/down counter datapath between programmable bounds under a start/done handshake. Supports one-shot sweeps, wrap-around repetition and ping-pong (bounce) sweeps with a programmable pass count. It sits between a control register block and the existing up/down counter style of datapath, sequencing the counter's load, enable and direction.

---
 rtl/updown_seq_pkg.sv | 15 +
 rtl/updown_step_core.sv | 35 +++
 rtl/updown_seq_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/updown_seq_pkg.sv
// Shared types and constants for the up/down counter sequencer.
package updown_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_WRAP    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

endpackage

// File: rtl/updown_step_core.sv
// N-bit up/down count register with synchronous load and step enable.
module updown_step_core #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] count
);

    logic [N-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? count_q + N'(1) : count_q - N'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// Sequencer for an up/down counter: one-shot, wrap and bounce sweeps between bounds.
// Optional PAUSE_EN adds a pause input that freezes the sweep while in RUN.
module updown_seq_ctrl
    import updown_seq_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned L = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         halt,
`ifdef PAUSE_EN
    input  logic         pause,
`endif
    input  logic [N-1:0] cfg_lo,
    input  logic [N-1:0] cfg_hi,
    input  logic         cfg_up,
    input  logic [1:0]   cfg_mode,
    input  logic [L-1:0] cfg_loops,
    output logic [N-1:0] count,
    output logic         dir_up,
    output logic         busy,
    output logic         tc,
    output logic         done,
    output logic         err
);

    state_e       state_q, state_d;
    logic [N-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [1:0]   mode_q, mode_d;
    logic [L-1:0] loops_q, loops_d, pass_q, pass_d, pass_inc;
    logic         dir_q, dir_d, err_q, err_d;

    logic         pause_w, run, at_bound, tc_w, last_pass, cfg_bad, accept, stepping;
    logic         ld, step_en, step_up;
    logic [N-1:0] ld_val;

`ifdef PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    updown_step_core #(.N(N)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .en       (step_en),
        .up       (step_up),
        .count    (count)
    );

    assign run       = (state_q == StRun);
    assign at_bound  = (count == (dir_q ? hi_q : lo_q));
    assign tc_w      = run && at_bound && !pause_w;
    assign pass_inc  = pass_q + L'(1);
    assign last_pass = (mode_q == MODE_ONESHOT) || ((loops_q != '0) && (pass_inc == loops_q));
    assign cfg_bad   = (cfg_lo > cfg_hi) || (cfg_mode == MODE_RSVD);
    assign accept    = (state_q == StIdle) && start && !cfg_bad;
    assign stepping  = run && !halt && !pause_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StRun;
            StRun: begin
                if (halt) begin
                    state_d = StIdle;
                end else if (tc_w && last_pass) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StFinish);
        tc   = tc_w;
    end

    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        mode_d  = mode_q;
        loops_d = loops_q;
        pass_d  = pass_q;
        dir_d   = dir_q;
        err_d   = (state_q == StIdle) && start && cfg_bad;
        ld      = 1'b0;
        ld_val  = count;
        step_en = 1'b0;
        step_up = dir_q;
        if (accept) begin
            lo_d    = cfg_lo;
            hi_d    = cfg_hi;
            mode_d  = cfg_mode;
            loops_d = cfg_loops;
            pass_d  = '0;
            dir_d   = cfg_up;
            ld      = 1'b1;
            ld_val  = cfg_up ? cfg_lo : cfg_hi;
        end else if (stepping) begin
            if (!at_bound) begin
                step_en = 1'b1;
            end else if (!last_pass) begin
                pass_d = pass_inc;
                if (mode_q == MODE_WRAP) begin
                    ld     = 1'b1;
                    ld_val = dir_q ? lo_q : hi_q;
                end else begin
                    // Bounce: turn around and take the first step of the return pass.
                    dir_d   = !dir_q;
                    step_en = (lo_q != hi_q);
                    step_up = !dir_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q    <= '0;
            hi_q    <= '0;
            mode_q  <= MODE_ONESHOT;
            loops_q <= '0;
            pass_q  <= '0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            mode_q  <= mode_d;
            loops_q <= loops_d;
            pass_q  <= pass_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign dir_up = dir_q;
    assign err    = err_q;

endmodule
